// File: rtl/logic_pkg.sv
// Op codes and the shared bitwise-op function for the logic unit and the ALU.
// Operands are handled at up to LOGIC_MAXW bits; callers cast to their own width.
package logic_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int LOGIC_MAXW = 64;

  function automatic logic [LOGIC_MAXW-1:0] logic_op(
    input logic [2:0]            op,
    input logic [LOGIC_MAXW-1:0] a,
    input logic [LOGIC_MAXW-1:0] b
  );
    logic [LOGIC_MAXW-1:0] r;
    r = '0;
    unique case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_slice.sv
// One valid/data register slice; loads when empty or when handing off downstream.
// Data only changes on a real load so a stalled slice keeps its contents stable.
module pipe_slice #(
  parameter int           W   = 17,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  input  logic         down_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic load;

  assign load     = ~valid | down_ready;
  assign up_ready = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: compute + zero flag, then STAGES register slices.
// Ready ripples combinationally from out_ready back to in_ready (no skid buffer).
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr
);

  localparam logic [WIDTH:0] SLICE_RST = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] res;
  logic             res_zr;

  // Unpacked so each link of the ready/valid chain is its own net.
  logic           v   [STAGES+1];
  logic           rdy [STAGES+1];
  logic [WIDTH:0] d   [STAGES+1];

  assign res    = WIDTH'(logic_op(op, LOGIC_MAXW'(a), LOGIC_MAXW'(b)));
  assign res_zr = ~|res;

  assign v[0]        = in_valid;
  assign d[0]        = {res_zr, res};
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipe_slice #(
      .W   (WIDTH + 1),
      .RST (SLICE_RST)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (v[k]),
      .up_data    (d[k]),
      .up_ready   (rdy[k]),
      .down_ready (rdy[k+1]),
      .valid      (v[k+1]),
      .data       (d[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES];
  assign {zr, out} = d[STAGES];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three configurations (16/2, 1/1, 32/4) with a
// reference model scoreboard, a hand-computed vector table and directed stall/reset runs.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;

  logic        ir [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic        zo [3];

  logic [15:0] o0;
  logic [0:0]  o1;
  logic [31:0] o2;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16), .STAGES(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .op(op), .a(a[15:0]), .b(b[15:0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out(o0), .zr(zo[0])
  );

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .op(op), .a(a[0:0]), .b(b[0:0]), .out_valid(ov[1]),
    .out_ready(out_ready), .out(o1), .zr(zo[1])
  );

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .op(op), .a(a), .b(b), .out_valid(ov[2]),
    .out_ready(out_ready), .out(o2), .zr(zo[2])
  );

  assign od[0] = {16'h0, o0};
  assign od[1] = {31'h0, o1};
  assign od[2] = o2;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit lat_chk = 1'b0;
  bit capt    = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        z;
    int          c;
  } ent_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        z;
  } vec_t;

  ent_t        sq [3][$];
  int          acc  [3];
  int          pops [3];
  logic [16:0] cap [$];
  vec_t        tbl [13];

  function automatic int stg(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] msk(input int k);
    case (k)
      0:       return 32'h0000_FFFF;
      1:       return 32'h0000_0001;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] mdl(input logic [2:0] o,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
  endtask

  // Scoreboard: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    ent_t        e;
    logic [31:0] m;
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) sq[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && out_ready) begin
          pops[k]++;
          if (k == 0 && capt) cap.push_back({zo[0], od[0][15:0]});
          chk($sformatf("sb_nonempty%0d", k), 32'(sq[k].size() != 0), 32'd1);
          if (sq[k].size() != 0) begin
            e = sq[k].pop_front();
            chk($sformatf("sb_out%0d", k), od[k], e.d);
            chk($sformatf("sb_zr%0d", k), 32'(zo[k]), 32'(e.z));
            if (lat_chk)
              chk($sformatf("sb_lat%0d", k), 32'(cyc - e.c), 32'(stg(k)));
          end
        end
        if (iv[k] && ir[k]) begin
          m = mdl(op, a, b) & msk(k);
          sq[k].push_back('{d: m, z: (m == 32'h0), c: cyc});
          acc[k]++;
        end
      end
    end
  end

  logic [2:0]  bp_op [5];
  logic [31:0] bp_a  [5];
  logic [31:0] bp_b  [5];
  logic [31:0] hold;
  int          idx;
  int          p0 [3];

  initial begin
    tbl[0]  = '{3'd0, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0};
    tbl[1]  = '{3'd1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    tbl[2]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0};
    tbl[3]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0};
    tbl[4]  = '{3'd4, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0};
    tbl[5]  = '{3'd5, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0};
    tbl[6]  = '{3'd6, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0};
    tbl[7]  = '{3'd7, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b0};
    tbl[8]  = '{3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b1};
    tbl[9]  = '{3'd0, 16'hFFFF, 16'h5555, 16'h0000, 1'b1};
    tbl[10] = '{3'd1, 16'h00FF, 16'hFF00, 16'h0000, 1'b1};
    tbl[11] = '{3'd5, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    tbl[12] = '{3'd6, 16'hAAAA, 16'h5555, 16'h0000, 1'b1};

    for (int j = 0; j < 5; j++) begin
      bp_op[j] = 3'(j + 1);
      bp_a[j]  = 32'hA5A5_0F0F + 32'(j * 32'h0101_0101);
      bp_b[j]  = 32'h3C3C_F00F ^ 32'(j * 32'h1111_1111);
    end
    for (int k = 0; k < 3; k++) begin
      acc[k]  = 0;
      pops[k] = 0;
    end

    // Reset
    rst_n = 1'b0;
    iv = 3'b000;
    out_ready = 1'b1;
    drv(3'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ov%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_out%0d", k), od[k], 32'd0);
      chk($sformatf("rst_zr%0d", k), 32'(zo[k]), 32'd1);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rel_ir%0d", k), 32'(ir[k]), 32'd1);

    // Vector table, back to back, all configurations
    step();
    capt = 1'b1;
    lat_chk = 1'b1;
    iv = 3'b111;
    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].op, {16'h0, tbl[i].a}, {16'h0, tbl[i].b});
      step();
    end
    iv = 3'b000;
    repeat (8) step();
    capt = 1'b0;
    lat_chk = 1'b0;
    chk("tbl_count", 32'(cap.size()), 32'd13);
    for (int i = 0; i < 13 && i < cap.size(); i++) begin
      chk($sformatf("tbl_out%0d", i), {16'h0, cap[i][15:0]}, {16'h0, tbl[i].o});
      chk($sformatf("tbl_zr%0d", i), 32'(cap[i][16]), 32'(tbl[i].z));
    end

    // Backpressure per configuration
    for (int k = 0; k < 3; k++) begin
      p0[k] = pops[k];
      out_ready = 1'b0;
      idx = 0;
      iv = 3'(1 << k);
      drv(bp_op[0], bp_a[0], bp_b[0]);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ir[k]) idx++;
        step();
        if (idx < 5) drv(bp_op[idx], bp_a[idx], bp_b[idx]);
      end
      chk($sformatf("bp_accepted%0d", k), 32'(idx), 32'(stg(k)));
      @(negedge clk);
      chk($sformatf("bp_ir%0d", k), 32'(ir[k]), 32'd0);
      chk($sformatf("bp_ov%0d", k), 32'(ov[k]), 32'd1);
      hold = od[k];
      repeat (3) @(negedge clk);
      chk($sformatf("bp_hold%0d", k), od[k], hold);
      step();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("bp_nogap%0d", k), 32'(ov[k]), 32'd1);
        if (iv[k] && ir[k]) idx++;
        step();
        if (idx < 5) drv(bp_op[idx], bp_a[idx], bp_b[idx]);
        else iv = 3'b000;
      end
      iv = 3'b000;
      repeat (6) step();
      chk($sformatf("bp_all_in%0d", k), 32'(idx), 32'd5);
      chk($sformatf("bp_pops%0d", k), 32'(pops[k] - p0[k]), 32'd5);
      chk($sformatf("bp_drained%0d", k), 32'(sq[k].size()), 32'd0);
    end

    // Full throughput with random ops
    for (int k = 0; k < 3; k++) p0[k] = pops[k];
    out_ready = 1'b1;
    lat_chk = 1'b1;
    iv = 3'b111;
    for (int i = 0; i < 100; i++) begin
      drv(3'($urandom_range(0, 7)), $urandom, $urandom);
      step();
    end
    iv = 3'b000;
    repeat (8) step();
    lat_chk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tp_pops%0d", k), 32'(pops[k] - p0[k]), 32'd100);
      chk($sformatf("tp_drained%0d", k), 32'(sq[k].size()), 32'd0);
    end

    // Mid-stream reset with transfers in flight
    iv = 3'b111;
    drv(3'd2, 32'h1357_9BDF, 32'h0F0F_0F0F);
    step();
    drv(3'd0, 32'h0000_0001, 32'h0);
    step();
    iv = 3'b000;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("mrst_ov%0d", k), 32'(ov[k]), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        chk($sformatf("mrst_stale%0d", k), 32'(ov[k]), 32'd0);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("mrst_ir%0d", k), 32'(ir[k]), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
